// File: rtl/game_pkg.sv
// Shared definitions for the box-striking game datapath.
//   game_state_e : sequencer states, encoded as presented on game_state
//   SENSOR_IDLE  : sensor/box code meaning "nothing struck"
//   TIME_W       : width of the seconds-remaining counter
package game_pkg;

  typedef enum logic [1:0] {
    LOBBY = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } game_state_e;

  localparam int SENSOR_IDLE = 0;
  localparam int TIME_W      = 7;

endpackage

// File: rtl/sensor_strike_sync.sv
// Brings the raw GPIO box code into the clock domain and turns it into
// single-cycle strike events.
//   clk_i          : system clock
//   rst_ni         : asynchronous active-low reset
//   sensor_i       : raw asynchronous box code (0 = idle)
//   strike_valid_o : high for one cycle when the synced code leaves idle
//   strike_box_o   : synced box code, meaningful while strike_valid_o is high
module sensor_strike_sync
  import game_pkg::*;
#(
  parameter int BOX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BOX_W-1:0] sensor_i,
  output logic             strike_valid_o,
  output logic [BOX_W-1:0] strike_box_o
);

  logic [BOX_W-1:0] meta_q;
  logic [BOX_W-1:0] sync_q;
  logic [BOX_W-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= sensor_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Only the idle -> nonzero edge counts, so a held sensor strikes once.
  assign strike_valid_o = (sync_q != BOX_W'(SENSOR_IDLE)) &&
                          (prev_q == BOX_W'(SENSOR_IDLE));
  assign strike_box_o   = sync_q;

endmodule

// File: rtl/whack_game_datapath.sv
// LOBBY/PLAY/OVER sequencer and scoring datapath for the box-striking game.
//   CLOCK_50    : system clock            resetn      : async active-low reset
//   start_game  : start / acknowledge     level       : difficulty, latched at start
//   sensor_addr : raw struck box code     rand_value  : LFSR value for target picks
//   target_box  : lit box (0 when idle)   score       : current score
//   time_left   : seconds remaining       game_state  : LOBBY=0 PLAY=1 OVER=2
//   hit_pulse / miss_pulse : one-cycle strike result strobes
//   play_sound  : hit sound enable        lobby_sound : high in LOBBY
//   game_over   : high in OVER
module whack_game_datapath
  import game_pkg::*;
#(
  parameter int N_BOXES      = 7,
  parameter int BOX_W        = 3,
  parameter int SCORE_W      = 11,
  parameter int GAME_SECONDS = 60,
  parameter int TICK_DIV     = 50_000_000,
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int SOUND_CYCLES = 12_500_000
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start_game,
  input  logic [1:0]         level,
  input  logic [BOX_W-1:0]   sensor_addr,
  input  logic [BOX_W-1:0]   rand_value,
  output logic [BOX_W-1:0]   target_box,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic [1:0]         game_state,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               play_sound,
  output logic               lobby_sound,
  output logic               game_over
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SND_W  = $clog2(SOUND_CYCLES + 1);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SND_W-1:0]   sound_q, sound_d;
  logic [BOX_W-1:0]   target_q, target_d;
  logic [1:0]         level_q, level_d;
  logic               hit_q, miss_q;

  logic               strike_valid;
  logic [BOX_W-1:0]   strike_box;
  logic               in_play, hit, miss, tick_wrap, final_tick, hold_expire;
  logic [31:0]        hold_limit;

  sensor_strike_sync #(.BOX_W(BOX_W)) u_sync (
    .clk_i          (CLOCK_50),
    .rst_ni         (resetn),
    .sensor_i       (sensor_addr),
    .strike_valid_o (strike_valid),
    .strike_box_o   (strike_box)
  );

  // Out-of-range LFSR values fall back to box 1; never re-pick the box that
  // is already lit, so the player always sees the target move.
  function automatic logic [BOX_W-1:0] next_target(input logic [BOX_W-1:0] rnd,
                                                   input logic [BOX_W-1:0] cur);
    logic [BOX_W-1:0] cand;
    // rnd-1 wraps for rnd==0, so one unsigned compare covers 1..N_BOXES.
    cand = ((32'(rnd) - 32'd1) < 32'(N_BOXES)) ? rnd : BOX_W'(1);
    if (cand == cur) begin
      cand = (cur == BOX_W'(N_BOXES)) ? BOX_W'(1) : cur + BOX_W'(1);
    end
    return cand;
  endfunction

  assign in_play     = (state_q == PLAY);
  assign hit         = in_play && strike_valid && (strike_box == target_q);
  assign miss        = in_play && strike_valid && (strike_box != target_q);
  assign tick_wrap   = in_play && (tick_q == TICK_W'(TICK_DIV - 1));
  assign final_tick  = tick_wrap && (time_q == TIME_W'(1));
  // Each difficulty step halves how long a target stays lit.
  assign hold_limit  = (32'(HOLD_CYCLES) >> level_q) - 32'd1;
  assign hold_expire = in_play && (32'(hold_q) == hold_limit);

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= LOBBY;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOBBY:   if (start_game) state_d = PLAY;
      PLAY:    if (final_tick) state_d = OVER;
      OVER:    if (start_game) state_d = LOBBY;
      default: state_d = LOBBY;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    game_state  = state_q;
    lobby_sound = (state_q == LOBBY);
    game_over   = (state_q == OVER);
  end

  // Datapath next values
  always_comb begin
    score_d  = score_q;
    time_d   = time_q;
    tick_d   = tick_q;
    hold_d   = hold_q;
    level_d  = level_q;
    target_d = target_q;
    // The sound keeps counting down in every state so it finishes after OVER.
    sound_d  = (sound_q != '0) ? sound_q - SND_W'(1) : sound_q;

    if ((state_q == LOBBY) && start_game) begin
      score_d  = '0;
      time_d   = TIME_W'(GAME_SECONDS);
      tick_d   = '0;
      hold_d   = '0;
      level_d  = level;
      target_d = next_target(rand_value, target_q);
    end else if (in_play) begin
      tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
      if (tick_wrap) time_d = time_q - TIME_W'(1);

      // Strikes are scored even on the final tick.
      if (hit) begin
        if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
        sound_d = SND_W'(SOUND_CYCLES);
      end else if (miss) begin
        if (score_q != '0) score_d = score_q - SCORE_W'(1);
      end

      // A hit coinciding with hold expiry reloads only once.
      if (hit || hold_expire) begin
        target_d = next_target(rand_value, target_q);
        hold_d   = '0;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end

      if (final_tick) target_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      score_q  <= '0;
      time_q   <= TIME_W'(GAME_SECONDS);
      tick_q   <= '0;
      hold_q   <= '0;
      sound_q  <= '0;
      target_q <= '0;
      level_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      score_q  <= score_d;
      time_q   <= time_d;
      tick_q   <= tick_d;
      hold_q   <= hold_d;
      sound_q  <= sound_d;
      target_q <= target_d;
      level_q  <= level_d;
      hit_q    <= hit;
      miss_q   <= miss;
    end
  end

  assign target_box = target_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign play_sound = (sound_q != '0);

endmodule

// File: tb/tb_whack_game_datapath.sv
module tb_whack_game_datapath;

  localparam int N  = 7;
  localparam int BW = 3;
  localparam int SW = 11;
  localparam int GS = 3;
  localparam int TD = 10;
  localparam int HC = 40;
  localparam int SC = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_game;
  logic [1:0]    level;
  logic [BW-1:0] sensor_addr;
  logic [BW-1:0] rand_value;
  logic [BW-1:0] target_box;
  logic [SW-1:0] score;
  logic [6:0]    time_left;
  logic [1:0]    game_state;
  logic          hit_pulse, miss_pulse, play_sound, lobby_sound, game_over;

  always #5 clk = ~clk;

  whack_game_datapath #(
    .N_BOXES(N), .BOX_W(BW), .SCORE_W(SW), .GAME_SECONDS(GS),
    .TICK_DIV(TD), .HOLD_CYCLES(HC), .SOUND_CYCLES(SC)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start_game(start_game), .level(level),
    .sensor_addr(sensor_addr), .rand_value(rand_value),
    .target_box(target_box), .score(score), .time_left(time_left),
    .game_state(game_state), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .play_sound(play_sound), .lobby_sound(lobby_sound), .game_over(game_over)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 lobby, 1 play, 2 over. Time is derived from elapsed play cycles,
  // sound from the edge number of the last hit.
  typedef struct { bit is_hit; int score; } ev_t;
  ev_t exp_q[$];
  int  samp[$];
  int  m_mode, m_score, m_tgt, m_elapsed, m_age, m_lvl, m_edge_n, m_last_hit;
  bit  m_hit_seen;

  function automatic int pick(input int r, input int cur);
    int cand;
    cand = (r >= 1 && r <= N) ? r : 1;
    if (cand == cur) cand = cur % N + 1;
    return cand;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_score = 0; m_tgt = 0; m_elapsed = 0; m_age = 0; m_lvl = 0;
    m_hit_seen = 0; m_last_hit = 0;
    samp.delete();
    repeat (3) samp.push_back(0);
    exp_q.delete();
  endtask

  task automatic m_edge(input int st, input int lv, input int sn, input int rn);
    int  s_new, s_old;
    bit  strike, reload;
    m_edge_n++;
    samp.push_back(sn);
    if (samp.size() > 8) void'(samp.pop_front());
    // A change sampled at edge e-2 after idle at e-3 is scored at edge e.
    s_new  = samp[samp.size()-3];
    s_old  = samp[samp.size()-4];
    strike = (s_new != 0) && (s_old == 0);
    case (m_mode)
      0: if (st != 0) begin
        m_mode = 1; m_score = 0; m_elapsed = 0; m_age = 0; m_lvl = lv;
        m_tgt = pick(rn, m_tgt);
      end
      1: begin
        reload = 0;
        if (strike && s_new == m_tgt) begin
          if (m_score < (1 << SW) - 1) m_score++;
          m_hit_seen = 1; m_last_hit = m_edge_n; reload = 1;
          exp_q.push_back('{1'b1, m_score});
        end else if (strike) begin
          if (m_score > 0) m_score--;
          exp_q.push_back('{1'b0, m_score});
        end
        m_age++;
        if (reload || m_age == (HC >> m_lvl)) begin
          m_tgt = pick(rn, m_tgt);
          m_age = 0;
        end
        m_elapsed++;
        if (m_elapsed == GS * TD) begin
          m_mode = 2; m_tgt = 0;
        end
      end
      default: if (st != 0) m_mode = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    int snd;
    snd = (m_hit_seen && (m_edge_n - m_last_hit) < SC) ? 1 : 0;
    chk({tag, ".state"},     game_state,  m_mode);
    chk({tag, ".score"},     score,       m_score);
    chk({tag, ".time_left"}, time_left,   GS - m_elapsed / TD);
    chk({tag, ".target"},    target_box,  m_tgt);
    chk({tag, ".sound"},     play_sound,  snd);
    chk({tag, ".lobby"},     lobby_sound, (m_mode == 0) ? 1 : 0);
    chk({tag, ".over"},      game_over,   (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!resetn) m_reset();
    else m_edge(start_game, level, sensor_addr, rand_value);
    #1;
    check_all(tag);
  endtask

  // ---------------- strike monitor ----------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (resetn && (hit_pulse || miss_pulse)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: hit=%0d miss=%0d, expected no strike", hit_pulse, miss_pulse);
        end else begin
          e = exp_q.pop_front();
          chk("ev.hit",   hit_pulse,  e.is_hit ? 1 : 0);
          chk("ev.miss",  miss_pulse, e.is_hit ? 0 : 1);
          chk("ev.score", score,      e.score);
          $display("strike %s score=%0d target=%0d", hit_pulse ? "hit " : "miss", score, target_box);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic run_until_elapsed(input string tag, input int target_elapsed);
    for (int i = 0; i < 60 && m_mode == 1 && m_elapsed < target_elapsed; i++) step(tag);
    chk({tag, ".reached"}, m_elapsed, target_elapsed);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0; start_game = 1'b0; level = 2'd0; sensor_addr = '0; rand_value = '0;
    m_reset();
    #12;
    check_all("reset");
    resetn = 1'b1;
    step("idle"); step("idle");

    // Game 1: start, hit, held sensor, misses, hit on the final tick.
    rand_value = 3'd4; start_game = 1'b1; step("g1_start"); start_game = 1'b0;
    chk("g1.target", target_box, 4);
    chk("g1.score", score, 0);
    chk("g1.time", time_left, 3);
    chk("g1.lobby", lobby_sound, 0);
    sensor_addr = 3'd4;
    repeat (3) step("g1_hit");
    chk("g1.hit_score", score, 1);
    chk("g1.hit_target", target_box, 5);
    repeat (3) step("g1_held");
    sensor_addr = '0; step("g1_rel");
    sensor_addr = 3'd2; repeat (3) step("g1_miss1");
    chk("g1.miss1_score", score, 0);
    sensor_addr = '0; step("g1_rel");
    sensor_addr = 3'd2; repeat (3) step("g1_miss2");
    chk("g1.miss2_score", score, 0);
    sensor_addr = '0;
    run_until_elapsed("g1_run", GS * TD - 3);
    sensor_addr = 3'(m_tgt);
    repeat (3) step("g1_final");
    chk("g1.final_score", score, 1);
    chk("g1.final_over", game_over, 1);
    chk("g1.final_target", target_box, 0);
    chk("g1.final_time", time_left, 0);
    sensor_addr = '0; step("g1_over");
    sensor_addr = 3'd3; repeat (4) step("g1_over_strike");
    sensor_addr = '0;
    start_game = 1'b1; step("g1_to_lobby"); start_game = 1'b0;
    chk("g1.lobby_state", game_state, 0);

    // Game 2: level 2, target rotation and reload boundary rules.
    level = 2'd2; rand_value = 3'd0; start_game = 1'b1; step("g2_start"); start_game = 1'b0;
    chk("g2.rand0_target", target_box, 1);
    rand_value = 3'd7;
    run_until_elapsed("g2_hold", 10);
    chk("g2.rotate_target", target_box, 7);
    run_until_elapsed("g2_hold", 20);
    chk("g2.wrap_target", target_box, 1);
    run_until_elapsed("g2_hold", GS * TD);
    start_game = 1'b1; step("g2_to_lobby"); start_game = 1'b0;

    // Game 3: three hits, then asynchronous reset while the sound runs.
    level = 2'd0; rand_value = 3'($urandom_range(0, 7)); start_game = 1'b1;
    step("g3_start"); start_game = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sensor_addr = 3'(m_tgt);
      for (int j = 0; j < 3; j++) begin
        rand_value = 3'($urandom_range(0, 7));
        step("g3_hit");
      end
      if (k < 2) begin
        sensor_addr = '0;
        step("g3_rel");
      end
    end
    chk("g3.score", score, 3);
    chk("g3.sound", play_sound, 1);
    #1;
    resetn = 1'b0;
    m_reset();
    #1;
    check_all("async_reset");
    sensor_addr = '0;
    #4;
    resetn = 1'b1;
    step("post_reset"); step("post_reset");

    // Game 4: random level, LFSR values and strikes.
    level = 2'($urandom_range(0, 3)); start_game = 1'b1; step("g4_start"); start_game = 1'b0;
    for (int i = 0; i < 60 && m_mode == 1; i++) begin
      rand_value = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: sensor_addr = '0;
        1: sensor_addr = 3'(m_tgt);
        2: sensor_addr = 3'($urandom_range(1, 7));
        default: ;
      endcase
      step("g4_rand");
    end
    chk("g4.over", game_over, 1);
    sensor_addr = '0;
    start_game = 1'b1; step("g4_to_lobby"); start_game = 1'b0;
    repeat (3) step("drain");
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/whack_game_datapath.md
Name: whack_game_datapath

Overview:
- Parametrised game datapath for the box-striking game: N target boxes, synchronised sensor strikes, hit/miss scoring, countdown game timer, difficulty-scaled target rotation and timed sound triggers.
- Sits between the Arduino sensor GPIO / LFSR and the VGA level selector and audio controller.
- Replaces the combinational `box == switch` compare with a full LOBBY/PLAY/OVER sequencer.

Parameters:
- N_BOXES, 7, number of targets; box codes 1..N_BOXES, code 0 = no strike.
- BOX_W, 3, width of box codes; must satisfy 2^BOX_W > N_BOXES.
- SCORE_W, 11, score width.
- GAME_SECONDS, 60, game length in seconds.
- TICK_DIV, 50_000_000, CLOCK_50 cycles per second tick.
- HOLD_CYCLES, 100_000_000, target hold time at level 0.
- SOUND_CYCLES, 12_500_000, length of the play_sound pulse.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start_game  in  1  synchronous start/acknowledge request.
- level  in  2  difficulty 0..3, sampled on LOBBY->PLAY.
- sensor_addr  in  BOX_W  raw asynchronous box code from GPIO (0 = idle).
- rand_value  in  BOX_W  LFSR output.
- target_box  out  BOX_W  current lit box (drives level select).
- score  out  SCORE_W  current score.
- time_left  out  7  seconds remaining.
- game_state  out  2  LOBBY=0, PLAY=1, OVER=2.
- hit_pulse  out  1  one-cycle hit strobe.
- miss_pulse  out  1  one-cycle wrong-box strobe.
- play_sound  out  1  hit sound enable.
- lobby_sound  out  1  high while in LOBBY.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (async, resetn=0):
  - state LOBBY; target_box=0; score=0; time_left=GAME_SECONDS.
  - All pulses and play_sound 0; lobby_sound=1; game_over=0.
  - Sync flops and counters cleared.
- Sensor path:
  - 2-flop synchroniser on sensor_addr.
  - A strike is a registered transition of the synced value from 0 to nonzero; a held value produces one strike only.
  - Latency: input change at edge n -> hit_pulse/miss_pulse/score update at edge n+3.
- LOBBY:
  - lobby_sound=1; strikes ignored.
  - start_game=1 -> PLAY next edge. On entry: score=0, time_left=GAME_SECONDS, tick counter=0, hold counter=0, level latched, target loaded.
- Target load rule:
  - candidate = rand_value if 1<=rand_value<=N_BOXES, else 1.
  - If candidate == current target_box, use target_box+1, wrapping N_BOXES->1.
- PLAY:
  - Strike == target_box: hit_pulse=1; score+1, saturating at 2^SCORE_W-1; play_sound held for SOUND_CYCLES cycles (a new hit restarts the count); new target loaded; hold counter cleared.
  - Strike on any other nonzero box: miss_pulse=1; score-1, floored at 0; target unchanged.
  - Hold counter reaches (HOLD_CYCLES>>level)-1 with no hit: new target loaded, score unchanged.
  - Tick counter wraps at TICK_DIV-1; on each wrap time_left decrements.
  - Wrap with time_left==1: time_left=0, state OVER.
- Simultaneous events:
  - A strike on the final-tick cycle is scored before entering OVER.
  - Hit and hold expiry on the same cycle: single target reload, hit counted.
- OVER:
  - game_over=1; target_box=0; score and time_left frozen; strikes ignored.
  - A running play_sound completes its count.
  - start_game=1 -> LOBBY.
- start_game during PLAY is ignored.
- resetn asserted mid-game returns every output to its reset value immediately.

Decomposition:
- Package game_pkg:
  - state encodings LOBBY/PLAY/OVER.
  - SENSOR_IDLE=0.
  - time_left width constant (7).
- One sub-module, sensor_strike_sync: synchroniser plus 0->nonzero strike detector, outputting strike_valid and strike_box.

Test Plan:
Bench parameters: N_BOXES=7, TICK_DIV=10, GAME_SECONDS=3, HOLD_CYCLES=40, SOUND_CYCLES=5.
1. Reset, start_game with rand_value=4 -> PLAY; target_box=4, score=0, time_left=3, lobby_sound=0.
2. sensor_addr 0->4 at edge n -> hit_pulse at n+3; score=1; play_sound high exactly 5 cycles; target reloads (rand_value=4 gives 5). Hold sensor at 4 -> no second hit.
3. Score 1, strike box 2 (target 5) -> miss_pulse, score 0; second miss -> score stays 0.
4. level=2, no strikes -> target changes every 10 cycles; rand_value=0 -> target 1; rand_value equal to current target -> target+1 (7 wraps to 1).
5. Run 30 cycles -> time_left 3,2,1,0; game_over=1, target_box=0. A hit on the final-tick cycle is counted. Later strikes ignored; start_game -> LOBBY.
6. Deassert resetn mid-PLAY with score=3 and play_sound high -> all outputs return to reset values the same cycle.
